hazard_sequencer_pipelined: RTL and testbench



---
 rtl/hazard_sequencer_pipelined.sv | 150 +++++++++++++++
 tb/tb_hazard_sequencer_pipelined.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer_pipelined.sv
// hazard_sequencer_pipelined: stall/flush/bubble sequencing, EX forwarding and data-memory wait control for a 5-stage RV32I pipeline
module hazard_sequencer_pipelined #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_wb_reg_file,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             ex_redirect,
  input  logic             dmem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic             bubble_wb,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             err_mem_timeout,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_mem_wait,
  output logic [CNT_W-1:0] cnt_redirect
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1) + 1;
  localparam logic [WCW-1:0] TIMEOUT = WCW'(MEM_TIMEOUT);
  localparam logic [1:0] FWD_ORG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {RUN, MEM_WAIT} state_e;
  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wb;
    logic       mrd;
    logic       mwr;
  } ex_slot_t;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wb;
    logic       mrd;
    logic       mwr;
  } mem_slot_t;
  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       wb;
  } wb_slot_t;

  state_e           state_q, state_d;
  ex_slot_t         ex_q, ex_d;
  mem_slot_t        mem_q, mem_d;
  wb_slot_t         wb_q, wb_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_lu_q, cnt_mw_q, cnt_rr_q;
  logic             mem_hold, redirect, load_use, mem_fwd_ok, wb_fwd_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && !(&c)) ? c + 1'b1 : c;
  endfunction

  // A pending MEM access freezes everything; redirect and load-use only act when the pipe moves.
  assign mem_hold   = mem_q.v & (mem_q.mrd | mem_q.mwr) & ~dmem_ready;
  assign redirect   = rst_n & ex_redirect & ~mem_hold;
  assign load_use   = ~mem_hold & ~ex_redirect & ex_q.v & ex_q.mrd & (|ex_q.rd) & id_valid &
                      ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));
  assign stall_if   = mem_hold | load_use;
  assign stall_id   = mem_hold | load_use;
  assign stall_ex   = mem_hold;
  assign stall_mem  = mem_hold;
  assign bubble_wb  = mem_hold;
  assign flush_id   = redirect;
  assign bubble_ex  = redirect | load_use;

  // Loads in MEM have no data yet, so only ALU results forward from MEM.
  assign mem_fwd_ok = mem_q.v & mem_q.wb & ~mem_q.mrd & (|mem_q.rd);
  assign wb_fwd_ok  = wb_q.v & wb_q.wb & (|wb_q.rd);
  assign forward_a  = ~ex_q.v ? FWD_ORG : (mem_fwd_ok & (mem_q.rd == ex_q.rs1)) ? FWD_MEM :
                      (wb_fwd_ok & (wb_q.rd == ex_q.rs1)) ? FWD_WB : FWD_ORG;
  assign forward_b  = ~ex_q.v ? FWD_ORG : (mem_fwd_ok & (mem_q.rd == ex_q.rs2)) ? FWD_MEM :
                      (wb_fwd_ok & (wb_q.rd == ex_q.rs2)) ? FWD_WB : FWD_ORG;

  assign err_mem_timeout = err_q;
  assign cnt_load_use    = cnt_lu_q;
  assign cnt_mem_wait    = cnt_mw_q;
  assign cnt_redirect    = cnt_rr_q;

  // Next state of the wait FSM, its timeout counter and the shadow slots.
  always_comb begin
    state_d = state_q == RUN ? (mem_hold ? MEM_WAIT : RUN) : (dmem_ready ? RUN : MEM_WAIT);
    wait_d  = state_q == MEM_WAIT ? (wait_q >= TIMEOUT ? wait_q : wait_q + 1'b1) : '0;
    err_d   = err_q | (wait_d >= TIMEOUT);
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    if (mem_hold) begin
      wb_d.v = 1'b0;
    end else begin
      wb_d  = '{v: mem_q.v, rd: mem_q.rd, wb: mem_q.wb};
      mem_d = '{v: ex_q.v, rd: ex_q.rd, wb: ex_q.wb, mrd: ex_q.mrd, mwr: ex_q.mwr};
      ex_d  = '{v: id_valid & ~bubble_ex, rs1: id_rs1, rs2: id_rs2, rd: id_rd,
                wb: id_wb_reg_file, mrd: id_mem_read, mwr: id_mem_write};
    end
  end

  // FSM, timeout flag and shadow slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      err_q   <= 1'b0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
    end
  end

  // Saturating hazard event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_lu_q <= '0;
      cnt_mw_q <= '0;
      cnt_rr_q <= '0;
    end else begin
      cnt_lu_q <= sat_inc(cnt_lu_q, load_use);
      cnt_mw_q <= sat_inc(cnt_mw_q, mem_hold);
      cnt_rr_q <= sat_inc(cnt_rr_q, redirect);
    end
  end
endmodule

// File: tb/tb_hazard_sequencer_pipelined.sv
// tb_hazard_sequencer_pipelined: directed scenarios plus randomized checking against an instruction-level pipeline model
module tb_hazard_sequencer_pipelined;
  localparam int TO  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clk, rst_n;
  logic          id_valid, id_use_rs1, id_use_rs2, id_wb_reg_file, id_mem_read, id_mem_write;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          ex_redirect, dmem_ready;
  logic          stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_wb;
  logic [1:0]    forward_a, forward_b;
  logic          err_mem_timeout;
  logic [CW-1:0] cnt_load_use, cnt_mem_wait, cnt_redirect;
  int            n_tests = 0;
  int            n_fail  = 0;

  hazard_sequencer_pipelined #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_wb_reg_file(id_wb_reg_file), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .ex_redirect(ex_redirect), .dmem_ready(dmem_ready), .stall_if(stall_if), .stall_id(stall_id),
    .stall_ex(stall_ex), .stall_mem(stall_mem), .flush_id(flush_id), .bubble_ex(bubble_ex),
    .bubble_wb(bubble_wb), .forward_a(forward_a), .forward_b(forward_b),
    .err_mem_timeout(err_mem_timeout), .cnt_load_use(cnt_load_use),
    .cnt_mem_wait(cnt_mem_wait), .cnt_redirect(cnt_redirect)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       wb;
    logic       mrd;
    logic       mwr;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_lu, m_mw, m_rr, m_wcnt;
  logic m_err, m_phold;

  function automatic logic f_hold();
    return m_mem.v && (m_mem.mrd || m_mem.mwr) && !dmem_ready;
  endfunction

  function automatic logic f_lu();
    return !f_hold() && !ex_redirect && m_ex.v && m_ex.mrd && m_ex.rd != 0 && id_valid &&
           ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
  endfunction

  function automatic logic [1:0] f_fwd(input logic [4:0] rs);
    if (!m_ex.v) return 2'b00;
    if (m_mem.v && m_mem.wb && !m_mem.mrd && m_mem.rd != 0 && m_mem.rd == rs) return 2'b01;
    if (m_wb.v && m_wb.wb && m_wb.rd != 0 && m_wb.rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [11:0] f_exp();
    logic h, r, l;
    h = f_hold();
    r = !h && ex_redirect;
    l = f_lu();
    if (!rst_n) return '0;
    return {h || l, h || l, h, h, r, r || l, h, f_fwd(m_ex.rs1), f_fwd(m_ex.rs2), m_err};
  endfunction

  // Instruction-level model: MEM_WAIT is simply "the previous cycle was held".
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ex <= '0; m_mem <= '0; m_wb <= '0;
      m_lu <= 0; m_mw <= 0; m_rr <= 0; m_wcnt <= 0; m_err <= 1'b0; m_phold <= 1'b0;
    end else begin
      m_lu    <= m_lu + ((f_lu() && m_lu < SAT) ? 1 : 0);
      m_mw    <= m_mw + ((f_hold() && m_mw < SAT) ? 1 : 0);
      m_rr    <= m_rr + ((!f_hold() && ex_redirect && m_rr < SAT) ? 1 : 0);
      m_wcnt  <= m_phold ? m_wcnt + 1 : 0;
      m_phold <= f_hold();
      if (m_phold && m_wcnt + 1 >= TO) m_err <= 1'b1;
      if (f_hold()) m_wb.v <= 1'b0;
      else begin
        m_wb  <= m_mem;
        m_mem <= m_ex;
        m_ex  <= '{id_valid && !ex_redirect && !f_lu(), id_rs1, id_rs2, id_rd,
                   id_wb_reg_file, id_mem_read, id_mem_write};
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rd = 0;
    id_wb_reg_file = 0; id_mem_read = 0; id_mem_write = 0; ex_redirect = 0; dmem_ready = 1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic wb, input logic mrd, input logic mwr);
    id_valid = 1; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; id_rd = rd;
    id_wb_reg_file = wb; id_mem_read = mrd; id_mem_write = mwr;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    #3;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle();
    ex_redirect = 1; dmem_ready = 0; id_valid = 1;
    #12;
    n_tests++;
    if ({stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_wb, forward_a, forward_b,
         err_mem_timeout, cnt_load_use, cnt_mem_wait, cnt_redirect} !== 24'h0) begin
      n_fail++; $display("FAIL reset_outputs: flush_id=%b stall_if=%b want all zero", flush_id, stall_if);
    end
    idle();
    tick();
    rst_n = 1;
    #1;
    n_tests++;
    if ({stall_if, stall_ex, flush_id, bubble_ex, bubble_wb, forward_a, forward_b, err_mem_timeout} !== 10'h0) begin
      n_fail++; $display("FAIL reset_release: stall_if=%b flush_id=%b want 0", stall_if, flush_id);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    issue(5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
    tick();
    issue(5'd5, 1, 5'd2, 1, 5'd6, 1, 0, 0);
    #1;
    n_tests++;
    if ({stall_if, stall_id, bubble_ex, stall_ex} !== 4'b1110) begin
      n_fail++; $display("FAIL load_use_stall: got %b want 1110", {stall_if, stall_id, bubble_ex, stall_ex});
    end
    tick();
    n_tests++;
    if (stall_if !== 1'b0 || cnt_load_use !== 4'd1) begin
      n_fail++; $display("FAIL load_use_release: stall_if=%b cnt=%0d want 0/1", stall_if, cnt_load_use);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if ({forward_a, forward_b} !== 4'b1000) begin
      n_fail++; $display("FAIL load_use_fwd_wb: got a=%b b=%b want a=10 b=00", forward_a, forward_b);
    end
  endtask

  task automatic test_forward_mem();
    do_reset();
    issue(5'd0, 1, 5'd0, 0, 5'd3, 1, 0, 0);
    tick();
    issue(5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0);
    #1;
    n_tests++;
    if (stall_if !== 1'b0 || bubble_ex !== 1'b0) begin
      n_fail++; $display("FAIL alu_dep_nostall: stall_if=%b bubble_ex=%b want 0", stall_if, bubble_ex);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if ({forward_a, forward_b} !== 4'b0101) begin
      n_fail++; $display("FAIL fwd_mem: got a=%b b=%b want 01/01", forward_a, forward_b);
    end
  endtask

  task automatic test_x0();
    do_reset();
    issue(5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 0);
    tick();
    issue(5'd0, 1, 5'd0, 1, 5'd7, 1, 0, 0);
    #1;
    n_tests++;
    if (stall_if !== 1'b0) begin
      n_fail++; $display("FAIL x0_nostall: stall_if=%b want 0", stall_if);
    end
    tick();
    idle();
    #1;
    n_tests++;
    if ({forward_a, forward_b} !== 4'b0000) begin
      n_fail++; $display("FAIL x0_fwd: got a=%b b=%b want 00/00", forward_a, forward_b);
    end
    issue(5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0);
    tick();
    issue(5'd0, 1, 5'd0, 1, 5'd9, 1, 0, 0);
    #1;
    n_tests++;
    if (stall_if !== 1'b0 || bubble_ex !== 1'b0) begin
      n_fail++; $display("FAIL x0_load_nostall: stall_if=%b bubble_ex=%b want 0", stall_if, bubble_ex);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    issue(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1);
    tick();
    idle();
    tick();
    dmem_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_tests++;
      if ({stall_if, stall_id, stall_ex, stall_mem, bubble_wb} !== 5'b11111) begin
        n_fail++; $display("FAIL mem_wait_cycle%0d: got %b want 11111", k,
                           {stall_if, stall_id, stall_ex, stall_mem, bubble_wb});
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    n_tests++;
    if ({stall_if, stall_id, stall_ex, stall_mem, bubble_wb} !== 5'b00000) begin
      n_fail++; $display("FAIL mem_wait_release: got %b want 00000", {stall_if, stall_id, stall_ex, stall_mem, bubble_wb});
    end
    tick();
    n_tests++;
    if (cnt_mem_wait !== 4'd3) begin
      n_fail++; $display("FAIL cnt_mem_wait: got %0d want 3", cnt_mem_wait);
    end
  endtask

  task automatic test_redirect_during_wait();
    do_reset();
    issue(5'd1, 1, 5'd0, 0, 5'd8, 1, 1, 0);
    tick();
    idle();
    tick();
    dmem_ready = 0;
    ex_redirect = 1;
    for (int k = 1; k <= 2; k++) begin
      #1;
      n_tests++;
      if (flush_id !== 1'b0 || bubble_ex !== 1'b0 || stall_if !== 1'b1) begin
        n_fail++; $display("FAIL redirect_held%0d: flush=%b bubble_ex=%b stall_if=%b want 0/0/1",
                           k, flush_id, bubble_ex, stall_if);
      end
      tick();
    end
    dmem_ready = 1;
    #1;
    n_tests++;
    if ({flush_id, bubble_ex, stall_if} !== 3'b110) begin
      n_fail++; $display("FAIL redirect_release: got %b want 110", {flush_id, bubble_ex, stall_if});
    end
    tick();
    ex_redirect = 0;
    n_tests++;
    if (cnt_redirect !== 4'd1 || cnt_mem_wait !== 4'd2) begin
      n_fail++; $display("FAIL redirect_counts: redirect=%0d mem_wait=%0d want 1/2", cnt_redirect, cnt_mem_wait);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(0, 149) != 0);
      id_valid       = ($urandom_range(0, 3) != 0);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_use_rs1     = 1'($urandom);
      id_use_rs2     = 1'($urandom);
      id_rd          = 5'($urandom_range(0, 3));
      id_wb_reg_file = 1'($urandom);
      id_mem_read    = ($urandom_range(0, 2) == 0);
      id_mem_write   = !id_mem_read && ($urandom_range(0, 4) == 0);
      ex_redirect    = ($urandom_range(0, 9) == 0);
      dmem_ready     = ($urandom_range(0, 3) != 0);
      #1;
      n_tests++;
      if ({stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_wb,
           forward_a, forward_b, err_mem_timeout} !== f_exp()) begin
        n_fail++; $display("FAIL rand_ctrl@%0d: got %b want %b", i, {stall_if, stall_id, stall_ex, stall_mem,
                           flush_id, bubble_ex, bubble_wb, forward_a, forward_b, err_mem_timeout}, f_exp());
      end
      n_tests++;
      if ({cnt_load_use, cnt_mem_wait, cnt_redirect} !== {CW'(m_lu), CW'(m_mw), CW'(m_rr)}) begin
        n_fail++; $display("FAIL rand_cnt@%0d: got %0d/%0d/%0d want %0d/%0d/%0d", i, cnt_load_use,
                           cnt_mem_wait, cnt_redirect, m_lu, m_mw, m_rr);
      end
      tick();
    end
    rst_n = 1;
  endtask

  task automatic test_timeout();
    do_reset();
    issue(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1);
    tick();
    idle();
    tick();
    dmem_ready = 0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      n_tests++;
      if (err_mem_timeout !== (k >= TO + 2)) begin
        n_fail++; $display("FAIL timeout_cycle%0d: err=%b want %b", k, err_mem_timeout, k >= TO + 2);
      end
      tick();
    end
    n_tests++;
    if (cnt_mem_wait !== 4'(SAT) || stall_mem !== 1'b1) begin
      n_fail++; $display("FAIL cnt_saturate: cnt=%0d stall_mem=%b want %0d/1", cnt_mem_wait, stall_mem, SAT);
    end
    ex_redirect = 1;
    rst_n = 0;
    #1;
    n_tests++;
    if ({stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, bubble_wb, forward_a, forward_b,
         err_mem_timeout, cnt_load_use, cnt_mem_wait, cnt_redirect} !== 24'h0) begin
      n_fail++; $display("FAIL timeout_reset: err=%b stall_if=%b cnt=%0d want all zero",
                         err_mem_timeout, stall_if, cnt_mem_wait);
    end
    idle();
    tick();
    rst_n = 1;
    issue(5'd1, 1, 5'd2, 1, 5'd0, 0, 0, 1);
    tick();
    idle();
    tick();
    #1;
    n_tests++;
    if (stall_mem !== 1'b0 || err_mem_timeout !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_run: stall_mem=%b err=%b want 0/0", stall_mem, err_mem_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward_mem();
    test_x0();
    test_mem_wait();
    test_redirect_during_wait();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
